snitch_tlb_refill_arbiter: RTL and testbench

// - Shares one L1 TLB / page-table-walker refill port between NrPorts L0 TLBs (e.g. ITLB, DTLB of one core).
// - Round-robin arbitration; one outstanding refill at a time.
// - Returns the PTE response to the granted L0 only.
// - Sits between the L0 TLB refill side (valid/ready/va, pte + is_4mega on ready) and the split req/rsp PTW interface.

---
 rtl/snitch_tlb_refill_arbiter_pkg.sv | 26 ++
 rtl/snitch_tlb_refill_arbiter_if.sv | 52 +++++
 rtl/snitch_tlb_refill_arbiter_rr.sv | 27 ++
 rtl/snitch_tlb_refill_arbiter.sv | 124 ++++++++++++
 tb/tb_snitch_tlb_refill_arbiter.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snitch_tlb_refill_arbiter_pkg.sv
// Shared types for the L0 TLB refill arbiter.
// Perf counters are built only with SNITCH_TLB_ARB_PERF_EN.
package snitch_tlb_refill_arbiter_pkg;

    typedef struct packed {
        logic [9:0]  vpn1;
        logic [9:0]  vpn0;
        logic [11:0] offs;
    } tlb_va_t;

    typedef struct packed {
        logic [21:0] ppn;
        logic [9:0]  flags;
    } tlb_pte_t;

    typedef enum logic [1:0] {
        ArbIdle,
        ArbReq,
        ArbWait
    } tlb_arb_state_e;

    function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/snitch_tlb_refill_arbiter_if.sv
// L0 refill side plus split PTW req/rsp bundle of the refill arbiter.
// Perf counters are built only with SNITCH_TLB_ARB_PERF_EN.
interface snitch_tlb_refill_arbiter_if
    import snitch_tlb_refill_arbiter_pkg::*;
#(
    parameter int unsigned NrPorts  = 2,
    parameter type         va_t     = tlb_va_t,
    parameter type         l0_pte_t = tlb_pte_t
);

    logic [NrPorts-1:0] l0_valid_i;
    logic [NrPorts-1:0] l0_ready_o;
    va_t  [NrPorts-1:0] l0_va_i;
    l0_pte_t            l0_pte_o;
    logic               l0_is_4mega_o;

    logic               ptw_req_valid_o;
    logic               ptw_req_ready_i;
    va_t                ptw_req_va_o;
    logic               ptw_rsp_valid_i;
    l0_pte_t            ptw_rsp_pte_i;
    logic               ptw_rsp_is_4mega_i;

    modport slave (
        input  l0_valid_i,
        input  l0_va_i,
        input  ptw_req_ready_i,
        input  ptw_rsp_valid_i,
        input  ptw_rsp_pte_i,
        input  ptw_rsp_is_4mega_i,
        output l0_ready_o,
        output l0_pte_o,
        output l0_is_4mega_o,
        output ptw_req_valid_o,
        output ptw_req_va_o
    );

    modport master (
        output l0_valid_i,
        output l0_va_i,
        output ptw_req_ready_i,
        output ptw_rsp_valid_i,
        output ptw_rsp_pte_i,
        output ptw_rsp_is_4mega_i,
        input  l0_ready_o,
        input  l0_pte_o,
        input  l0_is_4mega_o,
        input  ptw_req_valid_o,
        input  ptw_req_va_o
    );

endinterface

// File: rtl/snitch_tlb_refill_arbiter_rr.sv
// Round-robin pick: first valid requester at or after ptr_i, wrapping.
// Perf counters are built only with SNITCH_TLB_ARB_PERF_EN.
module snitch_tlb_refill_arbiter_rr #(
    parameter  int unsigned NrPorts = 2,
    localparam int unsigned IdxW    = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
    input  logic [NrPorts-1:0] valid_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic               any_o,
    output logic [IdxW-1:0]    idx_o
);

    always_comb begin
        int unsigned j;
        j     = 0;
        any_o = 1'b0;
        idx_o = '0;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            j = (32'(ptr_i) + i) % NrPorts;
            if (!any_o && valid_i[IdxW'(j)]) begin
                any_o = 1'b1;
                idx_o = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/snitch_tlb_refill_arbiter.sv
// Shares one PTW refill port between NrPorts L0 TLBs, one walk at a time.
// Define SNITCH_TLB_ARB_PERF_EN to add per-port refill/wait counters.
module snitch_tlb_refill_arbiter
    import snitch_tlb_refill_arbiter_pkg::*;
#(
    parameter int unsigned NrPorts  = 2,
    parameter type         va_t     = tlb_va_t,
    parameter type         l0_pte_t = tlb_pte_t
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
`ifdef SNITCH_TLB_ARB_PERF_EN
    output logic [NrPorts-1:0][31:0] perf_refill_o,
    output logic [NrPorts-1:0][31:0] perf_wait_o,
`endif
    snitch_tlb_refill_arbiter_if.slave bus
);

    localparam int unsigned IdxW = (NrPorts > 1) ? $clog2(NrPorts) : 1;

    tlb_arb_state_e  state;
    logic [IdxW-1:0] rr_ptr;
    logic [IdxW-1:0] gnt_idx;
    logic [IdxW-1:0] pick_idx;
    logic            pick_any;
    va_t             va_q;
    logic            drop_q;
    logic            rsp_in_wait;
    logic            deliver;
    l0_pte_t         pte_d;

    snitch_tlb_refill_arbiter_rr #(
        .NrPorts (NrPorts)
    ) i_rr (
        .valid_i (bus.l0_valid_i),
        .ptr_i   (rr_ptr),
        .any_o   (pick_any),
        .idx_o   (pick_idx)
    );

    assign rsp_in_wait = (state == ArbWait) && bus.ptw_rsp_valid_i;

    // A flush in the response cycle still drops it.
    assign deliver = rsp_in_wait && bus.l0_valid_i[gnt_idx]
                     && !drop_q && !flush_i;

    always_comb begin
        bus.l0_ready_o = '0;
        if (deliver) begin
            bus.l0_ready_o[gnt_idx] = 1'b1;
        end
    end

    assign pte_d             = rsp_in_wait ? bus.ptw_rsp_pte_i : l0_pte_t'('0);
    assign bus.l0_pte_o      = pte_d;
    assign bus.l0_is_4mega_o = rsp_in_wait & bus.ptw_rsp_is_4mega_i;
    assign bus.ptw_req_valid_o = (state == ArbReq);
    assign bus.ptw_req_va_o    = (state == ArbReq) ? va_q : va_t'('0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ArbIdle;
            rr_ptr  <= '0;
            gnt_idx <= '0;
            va_q    <= va_t'('0);
            drop_q  <= 1'b0;
        end else begin
            unique case (state)
                ArbIdle: begin
                    if (pick_any) begin
                        state   <= ArbReq;
                        gnt_idx <= pick_idx;
                        va_q    <= bus.l0_va_i[pick_idx];
                        rr_ptr  <= IdxW'(rr_next(32'(pick_idx), NrPorts));
                    end
                end
                ArbReq: begin
                    if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                    if (bus.ptw_req_ready_i) begin
                        state <= ArbWait;
                    end
                end
                ArbWait: begin
                    if (bus.ptw_rsp_valid_i) begin
                        state  <= ArbIdle;
                        drop_q <= 1'b0;
                    end else if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state <= ArbIdle;
            endcase
        end
    end

`ifdef SNITCH_TLB_ARB_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_refill_o <= '0;
            perf_wait_o   <= '0;
        end else begin
            for (int i = 0; i < NrPorts; i++) begin
                if (bus.l0_ready_o[i] && (perf_refill_o[i] != '1)) begin
                    perf_refill_o[i] <= perf_refill_o[i] + 32'd1;
                end
                if (bus.l0_valid_i[i] && !bus.l0_ready_o[i]
                    && (perf_wait_o[i] != '1)) begin
                    perf_wait_o[i] <= perf_wait_o[i] + 32'd1;
                end
            end
        end
    end
`endif

    a_rsp_in_wait: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.ptw_rsp_valid_i |-> (state == ArbWait));

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(bus.l0_ready_o));

endmodule

// File: tb/tb_snitch_tlb_refill_arbiter.sv
// Self-checking bench for snitch_tlb_refill_arbiter (NrPorts=2).
// Perf counter checks are built only with SNITCH_TLB_ARB_PERF_EN.
module tb_snitch_tlb_refill_arbiter;
    import snitch_tlb_refill_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    int   m_ptr  = 0;
    logic [1:0] exp_rdy = 2'b00;

    snitch_tlb_refill_arbiter_if #(.NrPorts(2)) bus ();

`ifdef SNITCH_TLB_ARB_PERF_EN
    logic [1:0][31:0] perf_refill;
    logic [1:0][31:0] perf_wait;
    int m_wait [2];
`endif

    snitch_tlb_refill_arbiter #(
        .NrPorts (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
`ifdef SNITCH_TLB_ARB_PERF_EN
        .perf_refill_o (perf_refill),
        .perf_wait_o   (perf_wait),
`endif
        .bus           (bus)
    );

    always #5 clk = ~clk;

`ifdef SNITCH_TLB_ARB_PERF_EN
    // Waiting cycles counted from what the L0s drive and what they should get.
    always @(negedge clk) begin
        if (rst) begin
            m_wait[0] = 0;
            m_wait[1] = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (bus.l0_valid_i[i] && !exp_rdy[i]) m_wait[i]++;
            end
        end
    end
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic int m_pick(input logic [1:0] v);
        for (int k = 0; k < 2; k++) begin
            int p;
            p = (m_ptr + k) % 2;
            if (v[p]) begin
                m_ptr = (p + 1) % 2;
                return p;
            end
        end
        return -1;
    endfunction

    function automatic tlb_va_t rand_va(input int p);
        logic [31:0] r;
        r = $urandom;
        r[0] = p[0];
        return tlb_va_t'(r);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        bus.l0_valid_i = 2'b00;
        bus.l0_va_i = '0;
        bus.ptw_req_ready_i = 1'b0;
        bus.ptw_rsp_valid_i = 1'b0;
        bus.ptw_rsp_pte_i = '0;
        bus.ptw_rsp_is_4mega_i = 1'b0;
        exp_rdy = 2'b00;
        m_ptr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        bus.l0_valid_i = 2'b11;
        bus.l0_va_i[0] = 32'h1234_5678;
        bus.ptw_req_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.ptw_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_valid got %b want 0", bus.ptw_req_valid_o);
        end
        checks++;
        if (bus.ptw_req_va_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_req_va got %h want 0", bus.ptw_req_va_o);
        end
        checks++;
        if (bus.l0_ready_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready got %b want 00", bus.l0_ready_o);
        end
        checks++;
        if (bus.l0_pte_o !== 32'h0 || bus.l0_is_4mega_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_pte got %h/%b want 0/0", bus.l0_pte_o, bus.l0_is_4mega_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.ptw_req_ready_i = 1'b0;
        bus.l0_valid_i = 2'b01;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.ptw_req_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_walk_start got %b want 1", bus.ptw_req_valid_o);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.ptw_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_walk got %b want 0", bus.ptw_req_valid_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.l0_valid_i = 2'b01;
        bus.l0_va_i[0] = 32'h8040_1000;
        @(negedge clk);
        checks++;
        if (bus.ptw_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_c0_req got %b want 0", bus.ptw_req_valid_o);
        end
        @(posedge clk);
        #1 bus.ptw_req_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ptw_req_valid_o !== 1'b1 || bus.ptw_req_va_o !== 32'h8040_1000) begin
            errors++;
            $display("FAIL single_c1_req got %b/%h want 1/80401000",
                     bus.ptw_req_valid_o, bus.ptw_req_va_o);
        end
        @(posedge clk);
        #1 bus.ptw_req_ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ptw_req_valid_o !== 1'b0 || bus.l0_ready_o !== 2'b00) begin
            errors++;
            $display("FAIL single_c2_wait got %b/%b want 0/00",
                     bus.ptw_req_valid_o, bus.l0_ready_o);
        end
        @(posedge clk);
        #1;
        bus.ptw_rsp_valid_i = 1'b1;
        bus.ptw_rsp_pte_i = {22'h123, 10'h0};
        bus.ptw_rsp_is_4mega_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.l0_ready_o !== 2'b01) begin
            errors++;
            $display("FAIL single_c3_ready got %b want 01", bus.l0_ready_o);
        end
        checks++;
        if (bus.l0_pte_o.ppn !== 22'h123 || bus.l0_is_4mega_o !== 1'b1) begin
            errors++;
            $display("FAIL single_c3_pte got %h/%b want 123/1",
                     bus.l0_pte_o.ppn, bus.l0_is_4mega_o);
        end
        @(posedge clk);
        #1;
        bus.ptw_rsp_valid_i = 1'b0;
        bus.l0_valid_i = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.l0_pte_o !== 32'h0 || bus.l0_is_4mega_o !== 1'b0) begin
            errors++;
            $display("FAIL single_pte_idle got %h/%b want 0/0",
                     bus.l0_pte_o, bus.l0_is_4mega_o);
        end
    endtask

    task automatic test_backpressure();
        tlb_va_t va;
        int g;
        int hs;
        do_reset();
        hs = 0;
        va = rand_va(1);
        bus.l0_valid_i = 2'b10;
        bus.l0_va_i[1] = va;
        g = m_pick(bus.l0_valid_i);
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            bus.ptw_req_ready_i = (k == 5);
            @(negedge clk);
            hs += int'(bus.ptw_req_valid_o && bus.ptw_req_ready_i);
            checks++;
            if (bus.ptw_req_valid_o !== 1'b1 || bus.ptw_req_va_o !== va) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got %b/%h want 1/%h",
                         k, bus.ptw_req_valid_o, bus.ptw_req_va_o, va);
            end
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 2; k++) begin
            bus.ptw_rsp_valid_i = (k == 1);
            @(negedge clk);
            hs += int'(bus.ptw_req_valid_o && bus.ptw_req_ready_i);
            if (k == 1) begin
                checks++;
                if (bus.l0_ready_o !== (2'b01 << g)) begin
                    errors++;
                    $display("FAIL bp_ready got %b want %b", bus.l0_ready_o, 2'b01 << g);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.ptw_rsp_valid_i = 1'b0;
        bus.ptw_req_ready_i = 1'b0;
        bus.l0_valid_i = 2'b00;
        checks++;
        if (hs !== 1) begin
            errors++;
            $display("FAIL bp_handshakes got %0d want 1", hs);
        end
    endtask

    task automatic test_contention();
        int last;
        int g;
        int dly;
        int seen [2];
        tlb_va_t exp_va;
        tlb_pte_t pte;
        logic m4;
        do_reset();
        last = -1;
        seen[0] = 0;
        seen[1] = 0;
        bus.l0_va_i[0] = rand_va(0);
        bus.l0_va_i[1] = rand_va(1);
        bus.l0_valid_i = 2'b11;
        for (int w = 0; w < 16; w++) begin
            g = m_pick(bus.l0_valid_i);
            exp_va = bus.l0_va_i[g];
            @(negedge clk);
            checks++;
            if (bus.ptw_req_valid_o !== 1'b0 || bus.l0_ready_o !== 2'b00) begin
                errors++;
                $display("FAIL cont_idle walk %0d got %b/%b want 0/00",
                         w, bus.ptw_req_valid_o, bus.l0_ready_o);
            end
            @(posedge clk);
            #1;
            if (last >= 0) begin
                bus.l0_valid_i[last] = 1'b1;
                bus.l0_va_i[last] = rand_va(last);
            end
            dly = $urandom_range(0, 3);
            for (int k = 0; k <= dly; k++) begin
                bus.ptw_req_ready_i = (k == dly);
                @(negedge clk);
                checks++;
                if (bus.ptw_req_valid_o !== 1'b1 || bus.ptw_req_va_o !== exp_va) begin
                    errors++;
                    $display("FAIL cont_req walk %0d got %b/%h want 1/%h",
                             w, bus.ptw_req_valid_o, bus.ptw_req_va_o, exp_va);
                end
                @(posedge clk);
                #1;
            end
            bus.ptw_req_ready_i = 1'b0;
            dly = $urandom_range(0, 3);
            pte = tlb_pte_t'($urandom);
            m4 = 1'($urandom_range(0, 1));
            for (int k = 0; k <= dly; k++) begin
                bus.ptw_rsp_valid_i = (k == dly);
                bus.ptw_rsp_pte_i = pte;
                bus.ptw_rsp_is_4mega_i = m4;
                exp_rdy = (k == dly) ? (2'b01 << g) : 2'b00;
                @(negedge clk);
                seen[0] += int'(bus.l0_ready_o[0]);
                seen[1] += int'(bus.l0_ready_o[1]);
                checks++;
                if (bus.l0_ready_o !== exp_rdy || bus.ptw_req_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL cont_ready walk %0d got %b/%b want %b/0",
                             w, bus.l0_ready_o, bus.ptw_req_valid_o, exp_rdy);
                end
                if (k == dly) begin
                    checks++;
                    if (bus.l0_pte_o !== pte || bus.l0_is_4mega_o !== m4) begin
                        errors++;
                        $display("FAIL cont_pte walk %0d got %h/%b want %h/%b",
                                 w, bus.l0_pte_o, bus.l0_is_4mega_o, pte, m4);
                    end
                end
                @(posedge clk);
                #1;
            end
            bus.ptw_rsp_valid_i = 1'b0;
            exp_rdy = 2'b00;
            bus.l0_valid_i[g] = 1'b0;
            last = g;
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (seen[i] !== 8) begin
                errors++;
                $display("FAIL cont_count port %0d got %0d want 8", i, seen[i]);
            end
        end
`ifdef SNITCH_TLB_ARB_PERF_EN
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (perf_refill[i] !== 32'd8) begin
                errors++;
                $display("FAIL perf_refill port %0d got %0d want 8", i, perf_refill[i]);
            end
            checks++;
            if (perf_wait[i] !== 32'(m_wait[i])) begin
                errors++;
                $display("FAIL perf_wait port %0d got %0d want %0d", i, perf_wait[i], m_wait[i]);
            end
        end
`endif
        bus.l0_valid_i = 2'b00;
    endtask

    task automatic test_flush();
        int p;
        int g;
        tlb_va_t va;
        logic [1:0] exp;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            p = $urandom_range(0, 1);
            va = rand_va(p);
            bus.l0_valid_i = 2'b00;
            bus.l0_valid_i[p] = 1'b1;
            bus.l0_va_i[p] = va;
            g = m_pick(bus.l0_valid_i);
            flush = (k == 3);
            @(posedge clk);
            #1;
            flush = (k == 2);
            bus.ptw_req_ready_i = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.ptw_req_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL flush_req case %0d got %b want 1", k, bus.ptw_req_valid_o);
            end
            @(posedge clk);
            #1;
            flush = (k == 0);
            bus.ptw_req_ready_i = 1'b0;
            @(posedge clk);
            #1 flush = 1'b0;
            @(posedge clk);
            #1;
            flush = (k == 1);
            bus.ptw_rsp_valid_i = 1'b1;
            exp = (k == 3) ? (2'b01 << g) : 2'b00;
            @(negedge clk);
            checks++;
            if (bus.l0_ready_o !== exp) begin
                errors++;
                $display("FAIL flush_rsp case %0d got %b want %b", k, bus.l0_ready_o, exp);
            end
            @(posedge clk);
            #1;
            flush = 1'b0;
            bus.ptw_rsp_valid_i = 1'b0;
            if (k == 3) bus.l0_valid_i = 2'b00;
            else g = m_pick(bus.l0_valid_i);
            @(posedge clk);
            #1 bus.ptw_req_ready_i = (k != 3);
            @(negedge clk);
            checks++;
            if (bus.ptw_req_valid_o !== 1'(k != 3)
                || (k != 3 && bus.ptw_req_va_o !== va)) begin
                errors++;
                $display("FAIL flush_regrant case %0d got %b/%h want %b/%h",
                         k, bus.ptw_req_valid_o, bus.ptw_req_va_o, k != 3, va);
            end
            @(posedge clk);
            #1 bus.ptw_req_ready_i = 1'b0;
            @(posedge clk);
            #1 bus.ptw_rsp_valid_i = (k != 3);
            exp = (k != 3) ? (2'b01 << g) : 2'b00;
            @(negedge clk);
            checks++;
            if (bus.l0_ready_o !== exp) begin
                errors++;
                $display("FAIL flush_fresh case %0d got %b want %b", k, bus.l0_ready_o, exp);
            end
            @(posedge clk);
            #1;
            bus.ptw_rsp_valid_i = 1'b0;
            bus.l0_valid_i = 2'b00;
        end
    endtask

    task automatic test_withdraw();
        tlb_pte_t pte;
        do_reset();
        pte = tlb_pte_t'($urandom);
        bus.l0_valid_i = 2'b10;
        bus.l0_va_i[1] = rand_va(1);
        @(posedge clk);
        #1 bus.ptw_req_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.ptw_req_ready_i = 1'b0;
        bus.l0_valid_i = 2'b00;
        @(posedge clk);
        #1;
        bus.ptw_rsp_valid_i = 1'b1;
        bus.ptw_rsp_pte_i = pte;
        @(negedge clk);
        checks++;
        if (bus.l0_ready_o !== 2'b00) begin
            errors++;
            $display("FAIL wd_ready got %b want 00", bus.l0_ready_o);
        end
        checks++;
        if (bus.l0_pte_o !== pte) begin
            errors++;
            $display("FAIL wd_pte got %h want %h", bus.l0_pte_o, pte);
        end
        @(posedge clk);
        #1 bus.ptw_rsp_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ptw_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL wd_idle got %b want 0", bus.ptw_req_valid_o);
        end
        @(posedge clk);
        #1;
        bus.l0_valid_i = 2'b01;
        bus.l0_va_i[0] = rand_va(0);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.ptw_req_valid_o !== 1'b1 || bus.ptw_req_va_o !== bus.l0_va_i[0]) begin
            errors++;
            $display("FAIL wd_next_req got %b/%h want 1/%h",
                     bus.ptw_req_valid_o, bus.ptw_req_va_o, bus.l0_va_i[0]);
        end
        @(posedge clk);
        #1 bus.l0_valid_i = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_contention();
        test_flush();
        test_withdraw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
